// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage and the program-counter register.
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

  localparam int INST_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch address, reads instruction memory over req/ack,
// holds the word for decode and mirrors fetch-address changes to the PC register.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEFAULT_RESET_PC)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              halt,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_target,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] inst_pc,
  output logic [DATA_W-1:0] PC_NEXT,
  output logic              W_PC,
  output logic              misalign_fault
);

  fetch_state_t      state, state_next;
  logic [DATA_W-1:0] fetch_pc, fetch_pc_next;
  logic [DATA_W-1:0] drain_addr, drain_addr_next;
  logic [DATA_W-1:0] inst_next, inst_pc_next, pc_next_next;
  logic              inst_valid_next, w_pc_next, fault_next;
  logic              target_aligned;

  assign target_aligned = (redirect_target[1:0] == 2'b00);

  // A drained request keeps its original address even after fetch_pc moves on.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : fetch_pc;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      drain_addr     <= RESET_PC;
      inst           <= '0;
      inst_pc        <= '0;
      inst_valid     <= 1'b0;
      PC_NEXT        <= RESET_PC;
      W_PC           <= 1'b0;
      misalign_fault <= 1'b0;
    end else begin
      state          <= state_next;
      fetch_pc       <= fetch_pc_next;
      drain_addr     <= drain_addr_next;
      inst           <= inst_next;
      inst_pc        <= inst_pc_next;
      inst_valid     <= inst_valid_next;
      PC_NEXT        <= pc_next_next;
      W_PC           <= w_pc_next;
      misalign_fault <= fault_next;
    end
  end

  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    drain_addr_next = drain_addr;
    inst_next       = inst;
    inst_pc_next    = inst_pc;
    inst_valid_next = inst_valid;
    pc_next_next    = PC_NEXT;
    w_pc_next       = 1'b0;
    fault_next      = misalign_fault;

    // Redirect outranks ack, accept and halt; a word taken in the same cycle is dropped.
    if (redirect && state != FAULT) begin
      inst_valid_next = 1'b0;
      if (!target_aligned) begin
        state_next = FAULT;
        fault_next = 1'b1;
      end else begin
        fetch_pc_next = redirect_target;
        pc_next_next  = redirect_target;
        w_pc_next     = 1'b1;
        unique case (state)
          IDLE:  state_next = halt ? IDLE : FETCH;
          FETCH: begin
            if (imem_ack) begin
              state_next = FETCH;
            end else begin
              state_next      = DRAIN;
              drain_addr_next = fetch_pc;
            end
          end
          HOLD:  state_next = FETCH;
          DRAIN: state_next = imem_ack ? FETCH : DRAIN;
          default: state_next = state;
        endcase
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (!halt) state_next = FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            inst_next       = imem_rdata;
            inst_pc_next    = fetch_pc;
            inst_valid_next = 1'b1;
            state_next      = HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            fetch_pc_next   = fetch_pc + DATA_W'(INST_BYTES);
            pc_next_next    = fetch_pc + DATA_W'(INST_BYTES);
            w_pc_next       = 1'b1;
            inst_valid_next = 1'b0;
            state_next      = halt ? IDLE : FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) state_next = halt ? IDLE : FETCH;
        end
        FAULT: begin
          inst_valid_next = 1'b0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; the bench plays instruction memory and decode.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_next;
  logic        w_pc;
  logic        misalign_fault;

  int checkCount = 0;
  int errorCount = 0;

  instruction_fetch #(
    .DATA_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .CLK            (clk),
    .RESET          (reset),
    .halt           (halt),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .PC_NEXT        (pc_next),
    .W_PC           (w_pc),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'hA5C3_0000 ^ {addr[15:0], addr[31:16]} ^ 32'h0000_1111;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int lat, input logic [31:0] addr);
    repeat (lat - 1) tick();
    imem_ack   = 1'b1;
    imem_rdata = memWord(addr);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_target = '0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b1;
    tick(); tick();
    checkOutput("rst_req",   {31'b0, imem_req},       32'd0);
    checkOutput("rst_valid", {31'b0, inst_valid},     32'd0);
    checkOutput("rst_inst",  inst,                    32'd0);
    checkOutput("rst_ipc",   inst_pc,                 32'd0);
    checkOutput("rst_pcn",   pc_next,                 32'd0);
    checkOutput("rst_wpc",   {31'b0, w_pc},           32'd0);
    checkOutput("rst_fault", {31'b0, misalign_fault}, 32'd0);

    $display("[TB] basic fetch, latency 2");
    reset = 1'b0;
    tick();
    checkOutput("f0_req",  {31'b0, imem_req}, 32'd1);
    checkOutput("f0_addr", imem_addr,         32'h0);
    applyStimulus(2, 32'h0);
    checkOutput("f0_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("f0_inst",  inst,                memWord(32'h0));
    checkOutput("f0_ipc",   inst_pc,             32'h0);
    checkOutput("f0_hreq",  {31'b0, imem_req},   32'd0);
    checkOutput("f0_hwpc",  {31'b0, w_pc},       32'd0);
    tick();
    checkOutput("f0_wpc",   {31'b0, w_pc},       32'd1);
    checkOutput("f0_pcn",   pc_next,             32'h4);
    checkOutput("f1_req",   {31'b0, imem_req},   32'd1);
    checkOutput("f1_addr",  imem_addr,           32'h4);
    checkOutput("f0_clr",   {31'b0, inst_valid}, 32'd0);

    $display("[TB] decode stall in HOLD");
    inst_ready = 1'b0;
    tick();
    checkOutput("f1_wpc0", {31'b0, w_pc}, 32'd0);
    applyStimulus(2, 32'h4);
    for (int i = 0; i < 5; i++) begin
      checkOutput("st_inst",  inst,                memWord(32'h4));
      checkOutput("st_ipc",   inst_pc,             32'h4);
      checkOutput("st_valid", {31'b0, inst_valid}, 32'd1);
      checkOutput("st_req",   {31'b0, imem_req},   32'd0);
      checkOutput("st_wpc",   {31'b0, w_pc},       32'd0);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    checkOutput("st_acc_wpc", {31'b0, w_pc}, 32'd1);
    checkOutput("st_acc_pcn", pc_next,       32'h8);
    checkOutput("f2_addr",    imem_addr,     32'h8);

    $display("[TB] redirect during outstanding fetch");
    redirect = 1'b1; redirect_target = 32'h100;
    tick();
    redirect = 1'b0;
    checkOutput("dr_wpc",  {31'b0, w_pc},     32'd1);
    checkOutput("dr_pcn",  pc_next,           32'h100);
    checkOutput("dr_req",  {31'b0, imem_req}, 32'd1);
    checkOutput("dr_addr", imem_addr,         32'h8);
    tick();
    checkOutput("dr_addr2", imem_addr,     32'h8);
    checkOutput("dr_wpc2",  {31'b0, w_pc}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    checkOutput("dr_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("dr_inst",  inst,                memWord(32'h4));
    checkOutput("dr_nreq",  {31'b0, imem_req},   32'd1);
    checkOutput("dr_naddr", imem_addr,           32'h100);
    checkOutput("dr_pcn2",  pc_next,             32'h100);

    $display("[TB] redirect together with ack");
    imem_ack = 1'b1; imem_rdata = memWord(32'h100);
    redirect = 1'b1; redirect_target = 32'h40;
    tick();
    imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    checkOutput("ra_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("ra_inst",  inst,                memWord(32'h4));
    checkOutput("ra_wpc",   {31'b0, w_pc},       32'd1);
    checkOutput("ra_pcn",   pc_next,             32'h40);
    checkOutput("ra_addr",  imem_addr,           32'h40);
    inst_ready = 1'b0;
    applyStimulus(1, 32'h40);
    checkOutput("rh_inst", inst, memWord(32'h40));
    inst_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h80;
    tick();
    redirect = 1'b0;
    checkOutput("rh_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rh_pcn",   pc_next,             32'h80);
    checkOutput("rh_addr",  imem_addr,           32'h80);
    checkOutput("rh_req",   {31'b0, imem_req},   32'd1);

    $display("[TB] misaligned redirect");
    redirect = 1'b1; redirect_target = 32'h102;
    tick();
    redirect = 1'b0;
    checkOutput("mf_fault", {31'b0, misalign_fault}, 32'd1);
    checkOutput("mf_req",   {31'b0, imem_req},       32'd0);
    checkOutput("mf_wpc",   {31'b0, w_pc},           32'd0);
    checkOutput("mf_pcn",   pc_next,                 32'h80);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    redirect = 1'b1; redirect_target = 32'h200;
    tick();
    redirect = 1'b0;
    tick();
    checkOutput("mf_req2",   {31'b0, imem_req},       32'd0);
    checkOutput("mf_fault2", {31'b0, misalign_fault}, 32'd1);
    checkOutput("mf_valid",  {31'b0, inst_valid},     32'd0);
    checkOutput("mf_pcn2",   pc_next,                 32'h80);
    reset = 1'b1;
    tick();
    checkOutput("mf_rfault", {31'b0, misalign_fault}, 32'd0);
    checkOutput("mf_rpcn",   pc_next,                 32'h0);
    reset = 1'b0;
    tick();
    checkOutput("mf_rreq",  {31'b0, imem_req}, 32'd1);
    checkOutput("mf_raddr", imem_addr,         32'h0);

    $display("[TB] address wrap and reset mid-fetch");
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    checkOutput("wr_daddr", imem_addr, 32'h0);
    checkOutput("wr_pcn",   pc_next,   32'hFFFF_FFFC);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    checkOutput("wr_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 32'hFFFF_FFFC);
    checkOutput("wr_ipc",  inst_pc, 32'hFFFF_FFFC);
    checkOutput("wr_inst", inst,    memWord(32'hFFFF_FFFC));
    tick();
    checkOutput("wr_wpc",   {31'b0, w_pc},     32'd1);
    checkOutput("wr_pcn0",  pc_next,           32'h0);
    checkOutput("wr_naddr", imem_addr,         32'h0);
    checkOutput("wr_nreq",  {31'b0, imem_req}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("rs_req",   {31'b0, imem_req},   32'd0);
    checkOutput("rs_valid", {31'b0, inst_valid}, 32'd0);
    halt = 1'b1; reset = 1'b0;
    tick(); tick();
    checkOutput("hl_req", {31'b0, imem_req}, 32'd0);
    halt = 1'b0;
    tick();
    checkOutput("hl_req2",  {31'b0, imem_req}, 32'd1);
    checkOutput("hl_addr2", imem_addr,         32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
